// File: rtl/param_data_mem.sv
// Parametrised single-port data memory for the MEM stage: byte-lane writes,
// registered reads behind a valid/ready handshake, and a post-reset fill sequencer.
module param_data_mem #(
  parameter int DATA_W        = 32,
  parameter int ADDR_W        = 5,
  parameter bit INIT_ON_RESET = 1'b1,
  parameter bit INIT_PATTERN  = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [DATA_W/8-1:0] req_be,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                init_busy
);

  localparam int DEPTH   = 2 ** ADDR_W;
  localparam int N_BYTES = DATA_W / 8;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   fill_cnt, fill_cnt_nx;
  logic                fill_we;
  logic [DATA_W-1:0]   fill_word;
  logic                accept, wr_accept, rd_accept;
  logic [DATA_W-1:0]   mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= INIT_ON_RESET ? ST_INIT : ST_RUN;
      fill_cnt <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state    <= state_nx;
      fill_cnt <= fill_cnt_nx;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
    state_nx    = state;
    fill_cnt_nx = fill_cnt;
    fill_we     = 1'b0;
    case (state)
      ST_INIT: begin
        fill_we     = 1'b1;
        fill_cnt_nx = fill_cnt + 1'b1;
        if (&fill_cnt) begin
          state_nx    = ST_RUN;
          fill_cnt_nx = '0;
        end
      end
      ST_RUN:  state_nx = ST_RUN;
      default: state_nx = ST_RUN;
    endcase
  end

  // Status outputs are forced low for as long as rst is held, not just after the edge.
  assign req_ready = (state == ST_RUN) && !rst;
  assign init_busy = (state == ST_INIT) && !rst;

  assign accept    = req_valid && req_ready;
  assign wr_accept = accept && req_we;
  assign rd_accept = accept && !req_we;
  assign fill_word = INIT_PATTERN ? DATA_W'(fill_cnt) : '0;

  // NOTE: the array has no reset so contents survive rst when the fill is disabled.
  always_ff @(posedge clk) begin
    if (fill_we && !rst) begin
      mem[fill_cnt] <= fill_word;
    end else if (wr_accept) begin
      for (int k = 0; k < N_BYTES; k++) begin
        if (req_be[k]) mem[req_addr][8*k +: 8] <= req_wdata[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= rd_accept;
      if (rd_accept) rsp_rdata <= mem[req_addr];
    end
  end

endmodule
